// File: rtl/id_ex_register_if.sv
// Decode-to-execute bundle: decoded instruction in, EX-stage copy, stall and event counters out.
// The master drives the id_* side and flush; the slave (pipeline register) drives ex_*, stall and counters.
interface id_ex_register_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [1:0]       id_ALUOp;
  logic             id_Branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite;
  logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]       id_rs1, id_rs2, id_rd;
  logic [3:0]       id_funct;
  logic             flush;

  logic             ex_valid;
  logic [1:0]       ex_ALUOp;
  logic             ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite;
  logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]       ex_rs1, ex_rs2, ex_rd;
  logic [3:0]       ex_funct;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport master (
    output id_valid, id_ALUOp, id_Branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc,
           id_RegWrite, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_funct, flush,
    input  ex_valid, ex_ALUOp, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc,
           ex_RegWrite, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_funct, stall, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_ALUOp, id_Branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc,
           id_RegWrite, id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_funct, flush,
    output ex_valid, ex_ALUOp, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc,
           ex_RegWrite, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd,
           ex_funct, stall, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use hazard stall, flush/stall bubbles and saturating event counters.
// Latency 1 cycle; stall is combinational and asks PC and IF/ID to hold the decode instruction.
module id_ex_register #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  id_ex_register_if.slave  bus
);

  logic             r_valid;
  logic [1:0]       r_aluop;
  logic             r_branch, r_memread, r_memtoreg, r_memwrite, r_alusrc, r_regwrite;
  logic [XLEN-1:0]  r_pc, r_rs1_data, r_rs2_data, r_imm;
  logic [4:0]       r_rs1, r_rs2, r_rd;
  logic [3:0]       r_funct;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic w_uses_rs2;
  logic w_hz;
  logic w_stall;
  logic w_load;

  // Immediate-form ALU ops ignore rs2, but stores still read it as the store data.
  assign w_uses_rs2 = ~bus.id_ALUSrc | bus.id_MemWrite;
  assign w_hz       = r_valid & r_memread & (r_rd != 5'd0) & bus.id_valid &
                      ((r_rd == bus.id_rs1) | (w_uses_rs2 & (r_rd == bus.id_rs2)));
  assign w_stall    = w_hz & ~bus.flush;
  assign w_load     = ~bus.flush & ~w_stall & bus.id_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_aluop     <= 2'b00;
      r_branch    <= 1'b0;
      r_memread   <= 1'b0;
      r_memtoreg  <= 1'b0;
      r_memwrite  <= 1'b0;
      r_alusrc    <= 1'b0;
      r_regwrite  <= 1'b0;
      r_pc        <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_rs1       <= 5'd0;
      r_rs2       <= 5'd0;
      r_rd        <= 5'd0;
      r_funct     <= 4'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      // Bubbles zero the control bits; datapath fields are captured regardless.
      r_valid    <= w_load;
      r_aluop    <= w_load ? bus.id_ALUOp : 2'b00;
      r_branch   <= w_load & bus.id_Branch;
      r_memread  <= w_load & bus.id_MemRead;
      r_memtoreg <= w_load & bus.id_MemtoReg;
      r_memwrite <= w_load & bus.id_MemWrite;
      r_alusrc   <= w_load & bus.id_ALUSrc;
      r_regwrite <= w_load & bus.id_RegWrite;
      r_pc       <= bus.id_pc;
      r_rs1_data <= bus.id_rs1_data;
      r_rs2_data <= bus.id_rs2_data;
      r_imm      <= bus.id_imm;
      r_rs1      <= bus.id_rs1;
      r_rs2      <= bus.id_rs2;
      r_rd       <= bus.id_rd;
      r_funct    <= bus.id_funct;
      if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (bus.flush && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.ex_valid    = r_valid;
  assign bus.ex_ALUOp    = r_aluop;
  assign bus.ex_Branch   = r_branch;
  assign bus.ex_MemRead  = r_memread;
  assign bus.ex_MemtoReg = r_memtoreg;
  assign bus.ex_MemWrite = r_memwrite;
  assign bus.ex_ALUSrc   = r_alusrc;
  assign bus.ex_RegWrite = r_regwrite;
  assign bus.ex_pc       = r_pc;
  assign bus.ex_rs1_data = r_rs1_data;
  assign bus.ex_rs2_data = r_rs2_data;
  assign bus.ex_imm      = r_imm;
  assign bus.ex_rs1      = r_rs1;
  assign bus.ex_rs2      = r_rs2;
  assign bus.ex_rd       = r_rd;
  assign bus.ex_funct    = r_funct;
  assign bus.stall       = w_stall;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_register.sv
// Directed-vector bench for id_ex_register: reset, pass-through, load-use stalls, flush priority, counter saturation.
module tb_id_ex_register;
  localparam int XLEN  = 64;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  id_ex_register_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  id_ex_register #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs are then driven and outputs sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] aluop, input logic br, input logic mr,
                       input logic m2r, input logic mw, input logic src, input logic rw,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [63:0] imm, input logic fl);
    bus.id_valid    = v;
    bus.id_ALUOp    = aluop;
    bus.id_Branch   = br;
    bus.id_MemRead  = mr;
    bus.id_MemtoReg = m2r;
    bus.id_MemWrite = mw;
    bus.id_ALUSrc   = src;
    bus.id_RegWrite = rw;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_rd       = rd;
    bus.id_imm      = imm;
    bus.id_pc       = 64'h1000 + {59'd0, rd};
    bus.id_rs1_data = 64'hAAAA_0000 + {59'd0, rs1};
    bus.id_rs2_data = 64'hBBBB_0000 + {59'd0, rs2};
    bus.id_funct    = 4'h3;
    bus.flush       = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 64'd0, 1'b0);
  endtask

  // Load: rd <- mem[rs1 + imm]
  task automatic load(input logic [4:0] rd);
    drive(1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1, 5'd0, rd, 64'h10, 1'b0);
  endtask

  initial begin
    // Reset with arbitrary, active-looking inputs
    reset = 1'b1;
    drive(1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd4, 5'd6, 5'd9, 64'hDEAD, 1'b1);
    tick();
    tick();
    check("rst_ex_valid", {63'd0, bus.ex_valid}, 64'd0);
    check("rst_ex_ctrl", {56'd0, bus.ex_ALUOp, bus.ex_Branch, bus.ex_MemRead, bus.ex_MemtoReg,
                          bus.ex_MemWrite, bus.ex_ALUSrc, bus.ex_RegWrite}, 64'd0);
    check("rst_ex_imm", bus.ex_imm, 64'd0);
    check("rst_ex_pc", bus.ex_pc, 64'd0);
    check("rst_ex_rd", {59'd0, bus.ex_rd}, 64'd0);
    check("rst_stall", {63'd0, bus.stall}, 64'd0);
    check("rst_cnts", {56'd0, bus.stall_cnt, bus.flush_cnt}, 64'd0);
    reset = 1'b0;

    // R-type pass-through
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd1, 5'd2, 5'd5, 64'h1234, 1'b0);
    check("rt_stall_pre", {63'd0, bus.stall}, 64'd0);
    tick();
    idle();
    check("rt_ex_valid", {63'd0, bus.ex_valid}, 64'd1);
    check("rt_ex_aluop", {62'd0, bus.ex_ALUOp}, 64'd2);
    check("rt_ex_regwrite", {63'd0, bus.ex_RegWrite}, 64'd1);
    check("rt_ex_memread", {63'd0, bus.ex_MemRead}, 64'd0);
    check("rt_ex_rd", {59'd0, bus.ex_rd}, 64'd5);
    check("rt_ex_imm", bus.ex_imm, 64'h1234);
    check("rt_ex_pc", bus.ex_pc, 64'h1005);
    check("rt_stall", {63'd0, bus.stall}, 64'd0);

    // Load rd=7, then R-type reading x7 through rs2
    load(5'd7);
    tick();
    check("lu_ex_memread", {63'd0, bus.ex_MemRead}, 64'd1);
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 5'd7, 5'd8, 64'h0, 1'b0);
    check("lu_stall", {63'd0, bus.stall}, 64'd1);
    tick();
    check("lu_bubble_valid", {63'd0, bus.ex_valid}, 64'd0);
    check("lu_bubble_ctrl", {56'd0, bus.ex_ALUOp, bus.ex_Branch, bus.ex_MemRead, bus.ex_MemtoReg,
                             bus.ex_MemWrite, bus.ex_ALUSrc, bus.ex_RegWrite}, 64'd0);
    check("lu_bubble_rd", {59'd0, bus.ex_rd}, 64'd8);
    check("lu_stall_clear", {63'd0, bus.stall}, 64'd0);
    check("lu_stall_cnt", {60'd0, bus.stall_cnt}, 64'd1);
    tick();
    idle();
    check("lu_dep_valid", {63'd0, bus.ex_valid}, 64'd1);
    check("lu_dep_rd", {59'd0, bus.ex_rd}, 64'd8);
    check("lu_dep_aluop", {62'd0, bus.ex_ALUOp}, 64'd2);
    check("lu_stall_cnt_hold", {60'd0, bus.stall_cnt}, 64'd1);

    // Load rd=9, then store of x9 (rs2 used despite ALUSrc=1)
    load(5'd9);
    tick();
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd4, 5'd9, 5'd0, 64'h8, 1'b0);
    check("st_stall", {63'd0, bus.stall}, 64'd1);
    tick();
    check("st_bubble_memwrite", {63'd0, bus.ex_MemWrite}, 64'd0);
    check("st_stall_cnt", {60'd0, bus.stall_cnt}, 64'd2);
    tick();
    check("st_ex_memwrite", {63'd0, bus.ex_MemWrite}, 64'd1);

    // Load rd=0, then an instruction reading x0: no stall
    load(5'd0);
    tick();
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd11, 64'h0, 1'b0);
    check("x0_stall", {63'd0, bus.stall}, 64'd0);
    tick();
    idle();
    check("x0_ex_valid", {63'd0, bus.ex_valid}, 64'd1);
    check("x0_stall_cnt", {60'd0, bus.stall_cnt}, 64'd2);

    // Independent instruction after a load: no stall
    load(5'd12);
    tick();
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd13, 5'd14, 5'd15, 64'h0, 1'b0);
    check("indep_stall", {63'd0, bus.stall}, 64'd0);

    // Reset while stalled
    load(5'd3);
    tick();
    drive(1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 5'd2, 5'd6, 64'h0, 1'b0);
    check("mid_stall", {63'd0, bus.stall}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_valid", {63'd0, bus.ex_valid}, 64'd0);
    check("mid_rst_cnts", {56'd0, bus.stall_cnt, bus.flush_cnt}, 64'd0);
    check("mid_rst_stall", {63'd0, bus.stall}, 64'd0);

    // Flush and hazard together: flush wins
    load(5'd3);
    tick();
    drive(1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 5'd2, 5'd6, 64'h0, 1'b1);
    check("fl_stall", {63'd0, bus.stall}, 64'd0);
    tick();
    idle();
    check("fl_bubble_valid", {63'd0, bus.ex_valid}, 64'd0);
    check("fl_bubble_branch", {63'd0, bus.ex_Branch}, 64'd0);
    check("fl_bubble_regwrite", {63'd0, bus.ex_RegWrite}, 64'd0);
    check("fl_flush_cnt", {60'd0, bus.flush_cnt}, 64'd1);
    check("fl_stall_cnt", {60'd0, bus.stall_cnt}, 64'd0);

    // Flush counter saturation (CNT_W=4)
    bus.flush = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    check("sat_reach", {60'd0, bus.flush_cnt}, 64'd15);
    for (int i = 0; i < 6; i++) tick();
    check("sat_hold", {60'd0, bus.flush_cnt}, 64'd15);
    bus.flush = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("sat_rst", {60'd0, bus.flush_cnt}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_ex_register.md
# id_ex_register

Decode-to-execute pipeline register for the RISC-V core. It sits directly downstream of the opcode control decoder and captures that decoder's control bundle, together with the decoded operands, into the EX stage. It also detects load-use hazards and drives the fetch/decode stall, inserts bubbles on stall or branch flush, and keeps saturating stall and flush event counters.

## Interface
- XLEN, 64, datapath width for register data, immediate and PC.
- CNT_W, 16, width of each event counter.

- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  decode holds a real instruction this cycle.
- id_ALUOp  in  2  ALU operation class from the control decoder.
- id_Branch, id_MemRead, id_MemtoReg, id_MemWrite, id_ALUSrc, id_RegWrite  in  1 each  control bits from the control decoder.
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  decoded operands.
- id_rs1, id_rs2, id_rd  in  5 each  register indices.
- id_funct  in  4  {funct7[5], funct3}.
- flush  in  1  branch taken in a later stage; kill the instruction in decode.
- ex_valid  out  1  EX holds a real instruction.
- ex_ALUOp, ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite  out  as inputs  registered control bits.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct  out  as inputs  registered operands.
- stall  out  1  combinational; tells PC and IF/ID to hold.
- stall_cnt, flush_cnt  out  CNT_W each  event counters.

## Operation
- The rs2 operand is in use when `uses_rs2 = ~id_ALUSrc | id_MemWrite` (R-type, branch, store).
- Hazard condition: `hz = ex_valid & ex_MemRead & (ex_rd != 0) & id_valid & ((ex_rd == id_rs1) | (uses_rs2 & ex_rd == id_rs2))`.
- `stall = hz & ~flush`. A flush kills the decode instruction, so no stall is raised for it.
- Each clock edge, in priority order:
  - **reset:** every output register and both counters go to 0.
  - **flush:** bubble.
  - **stall:** bubble. Upstream holds, so the same decode instruction is presented again next cycle.
  - **~id_valid:** bubble.
  - **otherwise:** load. ex_valid=1 and all control bits are copied from their id_* inputs.
- A bubble sets ex_valid=0 and forces every control bit to 0 (ALUOp=00). A bubble therefore never writes memory or registers, and never triggers a branch.
- Datapath fields (pc, data, imm, indices, funct) capture their id_* inputs on every non-reset edge, bubbles included. Consumers qualify these fields with ex_valid.
- Control inputs are don't-care when id_valid=0. The decoder's hold behaviour on unknown opcodes is masked by id_valid.
- **stall_cnt:** +1 on each non-reset edge where stall=1.
- **flush_cnt:** +1 on each non-reset edge where flush=1.
- Both counters saturate at all-ones and never wrap.

## Timing
- Latency is 1 cycle: decode inputs at edge N appear on ex_* after edge N.
- stall is purely combinational from current ex_* registers and current id_* inputs; it has no register stage.
- A load followed immediately by a dependent instruction produces exactly one stall cycle:
  - After the first bubble, ex_MemRead=0, so hz clears.
  - The dependent instruction then loads on the next edge.
- A load followed by an independent instruction causes no stall.
- A dependency on x0 (ex_rd=0) never stalls.
- If flush and hz are asserted in the same cycle: stall=0, bubble inserted, flush_cnt increments, stall_cnt does not.
- Reset asserted mid-stall: at the next edge ex_valid=0 and the counters are 0. stall is 0 from then on because ex_valid=0.
- Reset value of every output is 0, including stall, which is 0 while the registers are in reset state.

## Test plan
- **Reset:** assert reset 2 cycles with arbitrary inputs -> all ex_* = 0, ex_valid=0, stall=0, stall_cnt=flush_cnt=0.
- **R-type pass-through:** id_valid=1, ALUOp=10, RegWrite=1, rd=5, imm=0x1234 -> next cycle ex_valid=1, ex_ALUOp=10, ex_RegWrite=1, ex_rd=5, ex_imm=0x1234; stall stays 0.
- **Load-use:**
  - Stimulus: load rd=7, then an R-type with rs2=7 (ALUSrc=0).
  - Required: stall=1 for exactly one cycle, ex_valid=0 with all control 0 in the bubble cycle, then the R-type appears on EX; stall_cnt=1.
- **Store and x0:**
  - Load rd=9, then store with rs2=9 (ALUSrc=1, MemWrite=1) -> stall=1.
  - Load rd=0, then an instruction with rs1=0 -> stall=0.
- **Flush priority:** load rd=3, then a dependent instruction with flush=1 in the same cycle -> stall=0, bubble, flush_cnt=1, stall_cnt=0.
- **Counter saturation:** with CNT_W=4, hold flush=1 for 20 cycles -> flush_cnt reaches 15 and stays at 15; then reset -> flush_cnt=0.
